// File: rtl/store_align_buffer.sv
// Store alignment and 2-entry store buffer between the MEM stage and the data-memory write port.
// Places store data on byte lanes, drops misaligned/illegal stores, drains over mem_req/mem_ack.
module store_align_buffer (
  input  logic        clk,
  input  logic        rst,
  input  logic        st_valid,
  output logic        st_ready,
  input  logic [2:0]  st_sel,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_data,
  output logic        st_err,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ack,
  input  logic [31:0] ld_addr,
  output logic        ld_hit,
  output logic        sb_empty
);

  localparam int DEPTH = 2;

  logic [29:0] addr_r  [DEPTH];
  logic [31:0] wdata_r [DEPTH];
  logic [3:0]  wstrb_r [DEPTH];
  logic        wr_ptr_r;
  logic        rd_ptr_r;
  logic [1:0]  count_r;
  logic        err_r;

  logic [1:0]  off_s;
  logic [31:0] lane_wdata_s;
  logic [3:0]  lane_wstrb_s;
  logic        lane_err_s;
  logic        accept_s;
  logic        push_s;
  logic        pop_s;
  logic [1:0]  count_nxt_s;
  logic        unused_ld_off;

  assign unused_ld_off = ^ld_addr[1:0];

  // Lane placement, strobe generation and error classification of the incoming store
  always_comb begin
    off_s        = st_addr[1:0];
    lane_wdata_s = st_data;
    lane_wstrb_s = 4'b1111;
    lane_err_s   = 1'b0;
    case (st_sel)
      3'b000: begin
        lane_wdata_s = {4{st_data[7:0]}};
        lane_wstrb_s = 4'b0001 << off_s;
      end
      3'b001: begin
        lane_wdata_s = {2{st_data[15:0]}};
        lane_wstrb_s = off_s[1] ? 4'b1100 : 4'b0011;
        lane_err_s   = off_s[0];
      end
      3'b010: begin
        lane_wdata_s = st_data;
        lane_wstrb_s = 4'b1111;
        lane_err_s   = (off_s != 2'b00);
      end
      default: begin
        lane_err_s   = 1'b1;
      end
    endcase
  end

  assign st_ready = (count_r != 2'(DEPTH));
  assign accept_s = st_valid && st_ready;
  assign push_s   = accept_s && !lane_err_s;
  // mem_ack is only meaningful while a head entry is being presented
  assign pop_s    = mem_ack && (count_r != 2'd0);

  // Occupancy update for push-only, pop-only and push-with-pop
  always_comb begin
    count_nxt_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_nxt_s = count_r + 2'd1;
      2'b01:   count_nxt_s = count_r - 2'd1;
      default: count_nxt_s = count_r;
    endcase
  end

  // Pointer, occupancy and error-pulse registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= 1'b0;
      rd_ptr_r <= 1'b0;
      count_r  <= 2'd0;
      err_r    <= 1'b0;
    end else begin
      count_r <= count_nxt_s;
      err_r   <= accept_s && lane_err_s;
      if (push_s) begin
        wr_ptr_r <= ~wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= ~rd_ptr_r;
      end
    end
  end

  // Entry storage; cleared on reset so the idle payload reads as zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        addr_r[i]  <= 30'd0;
        wdata_r[i] <= 32'd0;
        wstrb_r[i] <= 4'd0;
      end
    end else if (push_s) begin
      addr_r[wr_ptr_r]  <= st_addr[31:2];
      wdata_r[wr_ptr_r] <= lane_wdata_s;
      wstrb_r[wr_ptr_r] <= lane_wstrb_s;
    end
  end

  assign st_err    = err_r;
  assign mem_req   = (count_r != 2'd0);
  assign sb_empty  = (count_r == 2'd0);
  assign mem_addr  = {addr_r[rd_ptr_r], 2'b00};
  assign mem_wdata = wdata_r[rd_ptr_r];
  assign mem_wstrb = wstrb_r[rd_ptr_r];

  // Only occupied slots take part in the hazard compare; the tail slot counts only when full
  assign ld_hit = ((count_r != 2'd0) && (addr_r[rd_ptr_r]  == ld_addr[31:2])) ||
                  ((count_r == 2'd2) && (addr_r[~rd_ptr_r] == ld_addr[31:2]));

endmodule
